// File: rtl/rsa_ctrl_pkg.sv
// Shared types and defaults for the RSA CPU run controller.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
//
// Contents:
//   run_state_t  - run sequencer FSM states
//   mem_owner_t  - which side currently drives the data-memory port
//   DEF_*        - default parameter values for run_sequencer
//   owner_of()   - maps a run state to its memory owner
package rsa_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  typedef enum logic {
    HOST = 1'b0,
    CPU  = 1'b1
  } mem_owner_t;

  localparam int unsigned DEF_DRAIN_CYCLES   = 4;
  localparam int unsigned DEF_MAX_RUN_CYCLES = 1048576;

  // The CPU keeps the memory port while it is running and while in-flight
  // stores retire; the host owns it otherwise.
  function automatic mem_owner_t owner_of(input run_state_t s);
    return ((s == RUN) || (s == DRAIN)) ? CPU : HOST;
  endfunction

endpackage

// File: rtl/mem_port_mux.sv
// Owner-select for the single data-memory port (host vs CPU store path).
// Latency: purely combinational, zero cycles.
// Backpressure: host_gnt is low whenever the CPU owns the port; host must hold its request.
//
// Ports:
//   owner                                    - current memory owner (decoded from registered state)
//   host_req/host_we/host_addr/host_wdata    - host access request
//   cpu_memwrite/cpu_addr/cpu_wdata          - CPU M-stage store port
//   mem_we/mem_addr/mem_wdata                - data RAM port
//   host_gnt                                 - host access accepted this cycle
module mem_port_mux
  import rsa_ctrl_pkg::*;
(
  input  mem_owner_t  owner,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  input  logic        cpu_memwrite,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        host_gnt
);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    host_gnt  = 1'b0;
    if (owner == CPU) begin
      mem_we    = cpu_memwrite;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else begin
      mem_we    = host_req & host_we;
      host_gnt  = host_req;
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Run controller for the RSA pipelined CPU: reset hold, start, end detect, store drain, memory hand-back.
// Latency: host_go -> RUN next cycle; cpu_end -> DONE after DRAIN_CYCLES+1; host read data 1 cycle after grant.
// Backpressure: host requests are refused (host_gnt=0) during RUN/DRAIN and must be held until granted.
//
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   host_go                        - one-cycle run request (honoured in IDLE/DONE only)
//   host_req/we/addr/wdata         - host memory access; host_gnt, host_rvalid, host_rdata responses
//   cpu_reset, cpu_start           - processor reset and start pulse
//   cpu_end                        - processor EndFlag
//   cpu_memwrite/addr/wdata        - processor store port; cpu_rdata is RAM read data
//   mem_we/addr/wdata, mem_rdata   - data RAM port (synchronous read, 1-cycle latency)
//   busy, done, timeout            - status; timeout is sticky until the next run starts
//   run_cycles                     - saturating count of RUN cycles
module run_sequencer
  import rsa_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
  parameter int unsigned MAX_RUN_CYCLES = DEF_MAX_RUN_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_go,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic        cpu_reset,
  output logic        cpu_start,
  input  logic        cpu_end,
  input  logic        cpu_memwrite,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] run_cycles
);

  localparam int unsigned DCW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [31:0] RUN_LIMIT  = 32'(MAX_RUN_CYCLES - 1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  run_state_t     state, state_nxt;
  mem_owner_t     owner;
  logic [DCW-1:0] drain_cnt;
  logic           start_q;
  logic           go_accept;
  logic           drain_load;
  logic           timeout_hit;
  logic           run_at_limit;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign run_at_limit = (run_cycles == RUN_LIMIT);

  always_comb begin
    state_nxt   = state;
    go_accept   = 1'b0;
    drain_load  = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (host_go) begin
          state_nxt = RUN;
          go_accept = 1'b1;
        end
      end
      RUN: begin
        // A real end always wins over a timeout landing in the same cycle.
        if (cpu_end) begin
          state_nxt  = DRAIN;
          drain_load = 1'b1;
        end else if (run_at_limit) begin
          state_nxt   = DONE;
          timeout_hit = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- counters and flags ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cycles  <= '0;
      timeout     <= 1'b0;
      drain_cnt   <= '0;
      start_q     <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      // start_q is high exactly in the first RUN cycle.
      start_q     <= go_accept;
      host_rvalid <= host_gnt & ~host_we;

      // The timeout cycle itself is not counted, so run_cycles stops at the limit.
      if (go_accept) begin
        run_cycles <= '0;
      end else if ((state == RUN) && !timeout_hit && (run_cycles != '1)) begin
        run_cycles <= run_cycles + 32'd1;
      end

      if (go_accept) begin
        timeout <= 1'b0;
      end else if (timeout_hit) begin
        timeout <= 1'b1;
      end

      if (drain_load) begin
        drain_cnt <= DRAIN_LOAD;
      end else if ((state == DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - 1'b1;
      end
    end
  end

  // ---------------- outputs ----------------
  // Ownership decodes the state flop only, so host_go never reaches the mux combinationally.
  assign owner      = owner_of(state);
  assign busy       = (owner == CPU);
  assign done       = (state == DONE);
  assign cpu_reset  = ~busy;
  assign cpu_start  = start_q;
  assign cpu_rdata  = mem_rdata;
  assign host_rdata = mem_rdata;

  mem_port_mux u_mux (
    .owner        (owner),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .cpu_memwrite (cpu_memwrite),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .host_gnt     (host_gnt)
  );

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Top-level run controller for the RSA pipelined CPU. It sequences a run: it holds the processor in reset while a host preloads data memory, releases it with a start pulse, and detects `EndFlag`. It then drains in-flight stores and hands memory back so the host can read results. It also arbitrates the single data-memory port between the host and the CPU's `MemWrite`/`ALUResult`/`WriteData` path.

## Interface
Parameters:
- `DRAIN_CYCLES`, 4: cycles the CPU keeps memory ownership after `cpu_end` so the pipeline can retire stores.
- `MAX_RUN_CYCLES`, 1048576: run-length limit that triggers a timeout.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `host_go` in 1: one-cycle request to start a run.
- `host_req` in 1: host memory access request.
- `host_we` in 1: host write enable.
- `host_addr` in 32: host address.
- `host_wdata` in 32: host write data.
- `host_gnt` out 1: host access accepted this cycle.
- `host_rvalid` out 1: `host_rdata` valid.
- `host_rdata` out 32: host read data.
- `cpu_reset` out 1: reset to the processor.
- `cpu_start` out 1: start pulse to the processor.
- `cpu_end` in 1: processor `EndFlag`.
- `cpu_memwrite` in 1, `cpu_addr` in 32, `cpu_wdata` in 32: processor M-stage store port.
- `cpu_rdata` out 32: processor read data (`ReadData`).
- `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_rdata` in 32: data RAM port. RAM read is synchronous with 1-cycle latency.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: high in DONE.
- `timeout` out 1: sticky until the next run starts.
- `run_cycles` out 32: cycles counted in RUN.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: host owns memory; `cpu_reset`=1. On `host_go`, go to RUN.
- RUN: CPU owns memory; `cpu_reset`=0.
  - `cpu_start`=1 in the first RUN cycle only.
  - `run_cycles` increments every RUN cycle.
  - On `cpu_end`, go to DRAIN.
  - If `run_cycles`==`MAX_RUN_CYCLES`-1 without `cpu_end`, set `timeout`=1 and go to DONE directly (no drain).
- DRAIN: CPU still owns memory; `cpu_reset`=0. A down-counter loads `DRAIN_CYCLES`-1 on entry. At 0, go to DONE.
- DONE: host owns memory; `cpu_reset`=1; `done`=1. On `host_go`, go to RUN.
- On entering RUN: clear `run_cycles`, `timeout` and `done`.
- `host_go` in RUN or DRAIN is ignored (no queuing).
- Memory mux:
  - When the host owns memory: `mem_we`=`host_req`&`host_we`, `mem_addr`=`host_addr`, `mem_wdata`=`host_wdata`, `host_gnt`=`host_req`.
  - When the CPU owns memory: `mem_we`=`cpu_memwrite`, `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_wdata`, `host_gnt`=0.
- Host protocol: a refused host request must be held stable until `host_gnt`.
- `cpu_rdata`=`mem_rdata` at all times.
- `host_rdata`=`mem_rdata`. `host_rvalid` is a registered flag: granted read (`host_gnt`&!`host_we`) delayed by 1 cycle.
- `run_cycles` saturates and never wraps.

## Timing
- Reset values: state IDLE, `cpu_reset`=1, `cpu_start`=0, `host_rvalid`=0, `busy`=0, `done`=0, `timeout`=0, `run_cycles`=0, drain counter 0.
- `mem_we` is combinational, so it is 0 during reset unless the host is requesting.
- Asynchronous `reset` mid-run: state goes to IDLE immediately, and the CPU is reset in the same cycle.
- `host_go`=1 in cycle t (IDLE/DONE): RUN in cycle t+1, with `cpu_start`=1 and `busy`=1 in t+1.
- `host_req` together with `host_go` in cycle t: the access is granted in t, because ownership changes at t+1.
- A read granted in t gives `host_rvalid`=1 in t+1, even if the state is RUN in t+1.
- `cpu_end` first high in cycle t: DRAIN during t+1..t+`DRAIN_CYCLES`, DONE at t+`DRAIN_CYCLES`+1.
- `cpu_end` during DRAIN or DONE is ignored.
- `cpu_memwrite` during DRAIN reaches memory; it does not during DONE.
- Ownership is a registered function of state, so there is no combinational path from `host_go` to the memory mux.

## Structure
- Package `rsa_ctrl_pkg`:
  - `run_state_t` enum (IDLE, RUN, DRAIN, DONE).
  - `mem_owner_t` enum (HOST, CPU).
  - Default constants for `DRAIN_CYCLES` and `MAX_RUN_CYCLES`.
- Sub-module `mem_port_mux`: combinational owner-select of `we`/`addr`/`wdata` plus `host_gnt`.
- FSM, counters and `host_rvalid` register stay in `run_sequencer`.

## Test plan
- Reset, then host writes 0xCAFEBABE to address 8, then reads address 8 → `host_gnt`=1, `mem_we`=1 for the write; the read returns `host_rvalid`=1 with `host_rdata`=0xCAFEBABE one cycle after grant; `cpu_reset` stays 1 throughout.
- `host_go` at cycle 10; CPU stores 0x55 to address 0x20 at cycle 15; `cpu_end` at cycle 20 → `cpu_start` only at cycle 11; `mem_we`=1 with `mem_addr`=0x20 at cycle 15; DRAIN at cycles 21–24; `done`=1 at cycle 25; `run_cycles`=10.
- `host_req` held during RUN → `host_gnt`=0 until DONE, then granted in the first DONE cycle.
- With `MAX_RUN_CYCLES`=16 and no `cpu_end` → `timeout`=1 and `done`=1 after 16 RUN cycles; `run_cycles`=15; DRAIN skipped.
- `reset` pulsed mid-DRAIN → state IDLE and `cpu_reset`=1 immediately; `done`=0; the next `host_go` runs normally.
- `host_go` pulsed during RUN, and `cpu_memwrite`=1 in the first DONE cycle → both ignored; `mem_we`=0 in that DONE cycle.
